// File: rtl/rr_arbiter4_v.sv
// Four-way round-robin arbiter with registered one-hot grant and a per-owner hold limit.
// A grant is released when the owner drops its request or, if others wait, after MAX_HOLD cycles.
module rr_arbiter4_v #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_busy,
    output logic       o_any_req
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       busy_q, busy_d;

    logic [2:0] win_idle;
    logic [2:0] win_next;
    logic [1:0] next_ptr;
    logic       owner_req;
    logic       others_req;
    logic       hold_done;

    // Returns {found, index} of the first set bit in rotating order start, start+1, ...
    function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
    endfunction

    assign next_ptr   = gnt_id_q + 2'd1;
    assign owner_req  = i_req[gnt_id_q];
    assign others_req = |(i_req & ~gnt_q);
    assign hold_done  = (hcnt_q == HoldLast);
    assign win_idle   = pick(i_req, ptr_q);
    assign win_next   = pick(i_req & ~gnt_q, next_ptr);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hcnt_d   = hcnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        case (state_q)
            StIdle: begin
                if (win_idle[2]) begin
                    state_d  = StGrant;
                    gnt_id_d = win_idle[1:0];
                    hcnt_d   = 8'd0;
                    busy_d   = 1'b1;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    ptr_d  = next_ptr;
                    hcnt_d = 8'd0;
                    if (win_next[2]) begin
                        gnt_id_d = win_next[1:0];
                    end else begin
                        state_d  = StIdle;
                        gnt_id_d = 2'd0;
                        busy_d   = 1'b0;
                    end
                end else if (hold_done) begin
                    // Timeout only rotates when someone else is actually waiting.
                    hcnt_d = 8'd0;
                    if (others_req) begin
                        ptr_d    = next_ptr;
                        gnt_id_d = win_next[1:0];
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                gnt_id_d = 2'd0;
                busy_d   = 1'b0;
                hcnt_d   = 8'd0;
            end
        endcase
        gnt_d = busy_d ? (4'b0001 << gnt_id_d) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            ptr_q    <= 2'd0;
            hcnt_q   <= 8'd0;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hcnt_q   <= hcnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = gnt_id_q;
    assign o_busy    = busy_q;
    assign o_any_req = |i_req;

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Directed vector table plus hand sequences and a random property run for rr_arbiter4_v.
// Three instances (hold limits 8, 4 and 1) share the same stimulus.
module tb_rr_arbiter4_v;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt8, gnt4, gnt1;
    logic [1:0] id8, id4, id1;
    logic       busy8, busy4, busy1;
    logic       any8, any4, any1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter4_v #(.MAX_HOLD(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt8), .o_gnt_id(id8), .o_busy(busy8), .o_any_req(any8)
    );
    rr_arbiter4_v #(.MAX_HOLD(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt4), .o_gnt_id(id4), .o_busy(busy4), .o_any_req(any4)
    );
    rr_arbiter4_v #(.MAX_HOLD(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .o_gnt(gnt1), .o_gnt_id(id1), .o_busy(busy1), .o_any_req(any1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        step();
        rst = 1'b0;
    endtask

    int         wait_cnt[4];
    int         max_wait;
    logic [3:0] r;
    logic       found;

    initial begin
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
        vecs[2]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[4]  = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[9]  = '{1'b0, 4'b1011, 4'b0001, 2'd0, 1'b1};
        vecs[10] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
        vecs[11] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[12] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[15] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[16] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

        #2;
        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            #1;
            check($sformatf("any_req[%0d]", i), 32'(any8), 32'(|vecs[i].req));
            step();
            check($sformatf("gnt[%0d]", i), 32'(gnt8), 32'(vecs[i].gnt));
            check($sformatf("gnt_id[%0d]", i), 32'(id8), 32'(vecs[i].id));
            check($sformatf("busy[%0d]", i), 32'(busy8), 32'(vecs[i].busy));
        end

        // Two contenders: hold limit 8 gives 8-cycle turns, limit 1 alternates every cycle.
        do_reset(4'b0011);
        for (int i = 0; i < 24; i++) begin
            step();
            check($sformatf("hold8[%0d]", i), 32'(gnt8),
                  (i < 8 || i >= 16) ? 32'h1 : 32'h2);
            check($sformatf("hold1[%0d]", i), 32'(gnt1), (i % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Lone requester keeps the grant through timeouts; a newcomer takes over soon.
        do_reset(4'b0100);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("lone4[%0d]", i), 32'(gnt4), 32'h4);
            check($sformatf("lone1[%0d]", i), 32'(gnt1), 32'h4);
        end
        req = 4'b0101;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (gnt4 == 4'b0001) begin
                found = 1'b1;
                break;
            end
        end
        check("takeover4", 32'(found), 32'h1);

        // Random stimulus with sticky requests; structural and fairness properties on limit 8.
        do_reset(4'b0000);
        r = 4'b0000;
        max_wait = 0;
        for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
            end
            req = r;
            step();
            check("onehot0", 32'($onehot0(gnt8)), 32'h1);
            check("gnt_to_req", 32'(gnt8 & ~r), 32'h0);
            check("busy_vs_gnt", 32'(busy8), 32'(|gnt8));
            check("id_vs_gnt", 32'(gnt8), busy8 ? 32'(4'b0001 << id8) : 32'h0);
            if (!busy8) check("id_idle", 32'(id8), 32'h0);
            for (int k = 0; k < 4; k++) begin
                if (r[k] && !gnt8[k]) wait_cnt[k]++;
                else wait_cnt[k] = 0;
                if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
            end
        end
        check("max_wait_le_28", 32'(max_wait <= 3 * 8 + 4), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
